// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide sharing one 2*WIDTH shift datapath, one bit per cycle.
// Magnitudes are processed in MUL/DIV; a single FIX cycle applies signs and loads the outputs.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  input  logic                    ctrl_MULT,
  input  logic                    ctrl_DIV,
  output logic signed [WIDTH-1:0] data_result,
  output logic signed [WIDTH-1:0] data_result_hi,
  output logic                    data_exception,
  output logic                    data_inputRDY,
  output logic                    data_resultRDY
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]        mag_q, mag_d;
  logic                    is_div_q, is_div_d;
  logic                    neg_res_q, neg_res_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    div_exc_q, div_exc_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic signed [WIDTH-1:0] result_hi_q, result_hi_d;
  logic                    exc_q, exc_d;
  logic                    rdy_q, rdy_d;

  logic [WIDTH:0]          mul_sum;
  logic [WIDTH:0]          rem_sh;
  logic [WIDTH-1:0]        rem_diff;
  logic                    rem_ge;
  logic [2*WIDTH-1:0]      prod_fix;
  logic [WIDTH-1:0]        quo_fix;
  logic [WIDTH-1:0]        rem_fix;

  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? ('0 - u) : u;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  // Product fits in WIDTH signed bits only when the top WIDTH+1 bits are a pure sign extension.
  function automatic logic fits_signed(input logic [2*WIDTH-1:0] p);
    logic [WIDTH:0] top;
    top = p[2*WIDTH-1:WIDTH-1];
    return (&top) | ~(|top);
  endfunction

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  // Divide: upper half is the partial remainder, lower half shifts dividend bits out and quotient bits in.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, mag_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - mag_q;

  assign prod_fix = cond_neg2(acc_q, neg_res_q);
  assign quo_fix  = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
  assign rem_fix  = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mag_d       = mag_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    div_exc_d   = div_exc_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    exc_d       = exc_q;
    rdy_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_MULT ^ ctrl_DIV) begin
          neg_res_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          neg_rem_d = data_operandA[WIDTH-1];
          is_div_d  = ctrl_DIV;
          cnt_d     = '0;
          div_exc_d = ($unsigned(data_operandB) == '0) ||
                      (($unsigned(data_operandA) == MIN_VAL) && ($unsigned(data_operandB) == '1));
          if (ctrl_MULT) begin
            mag_d   = abs_mag(data_operandA);
            acc_d   = {{WIDTH{1'b0}}, abs_mag(data_operandB)};
            state_d = MUL;
          end else begin
            mag_d   = abs_mag(data_operandB);
            acc_d   = {{WIDTH{1'b0}}, abs_mag(data_operandA)};
            state_d = DIV;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      DIV: begin
        acc_d = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          if (div_exc_q) begin
            result_d    = '0;
            result_hi_d = '0;
            exc_d       = 1'b1;
          end else begin
            result_d    = quo_fix;
            result_hi_d = rem_fix;
            exc_d       = 1'b0;
          end
        end else begin
          result_d    = prod_fix[WIDTH-1:0];
          result_hi_d = prod_fix[2*WIDTH-1:WIDTH];
          exc_d       = ~fits_signed(prod_fix);
        end
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mag_q       <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_exc_q   <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mag_q       <= mag_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      div_exc_q   <= div_exc_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      exc_q       <= exc_d;
      rdy_q       <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_result_hi = result_hi_q;
  assign data_exception = exc_q;
  assign data_inputRDY  = (state_q == IDLE);
  assign data_resultRDY = rdy_q;

endmodule
